// File: rtl/rd_line_sched.sv
// -----------------------------------------------------------------------------
// rd_line_sched
//   DDR read scheduler for the display read path. Each line_req fetches one
//   video line for every enabled channel from a ping-pong frame store. Lines
//   longer than MAX_BURST beats are split into several bursts. Lines are
//   walked top-down, or bottom-up when rotate_180 was set at frame_start.
//   Returned beats are given line-buffer write addresses.
//
// Ports
//   ddr_clk, ddr_rst          clock, synchronous active-high reset
//   frame_start, line_req     one-cycle control pulses from the vout side
//   rotate_180, frame_idx,
//   ch_en                     frame parameters, sampled at frame_start
//   ddr_rreq/raddr/rd_len/
//   part, ddr_rrdy            read request handshake towards the controller
//   ddr_rdata_en, ddr_rdone   returned beat strobe / burst complete
//   buf_wr_en, buf_wr_addr    line-buffer write port
//   line_cnt, busy,
//   frame_done, err_flags     status ([0] request overrun, [1] beat mismatch)
// -----------------------------------------------------------------------------
module rd_line_sched #(
    parameter int          ADDR_WIDTH      = 27,
    parameter logic [31:0] ADDR_OFFSET     = 32'h0,
    parameter int          H_NUM           = 1920,
    parameter int          V_NUM           = 1080,
    parameter int          DQ_WIDTH        = 32,
    parameter int          PIX_WIDTH       = 24,
    parameter int          LEN_WIDTH       = 16,
    parameter int          MAX_BURST       = 64,
    parameter int          CH_NUM          = 4,
    parameter int          CH_SEL_WIDTH    = 2,
    parameter int          LINE_ADDR_WIDTH = 19,
    parameter int          FRAME_IDX_WIDTH = 1,
    parameter int          BUF_ADDR_WIDTH  = 11
) (
    input  logic                       ddr_clk,
    input  logic                       ddr_rst,
    input  logic                       frame_start,
    input  logic                       line_req,
    input  logic                       rotate_180,
    input  logic [FRAME_IDX_WIDTH-1:0] frame_idx,
    input  logic [CH_NUM-1:0]          ch_en,
    output logic                       ddr_rreq,
    output logic [ADDR_WIDTH-1:0]      ddr_raddr,
    output logic [LEN_WIDTH-1:0]       ddr_rd_len,
    output logic [CH_SEL_WIDTH-1:0]    ddr_part,
    input  logic                       ddr_rrdy,
    input  logic                       ddr_rdata_en,
    input  logic                       ddr_rdone,
    output logic                       buf_wr_en,
    output logic [BUF_ADDR_WIDTH-1:0]  buf_wr_addr,
    output logic [11:0]                line_cnt,
    output logic                       busy,
    output logic                       frame_done,
    output logic [1:0]                 err_flags
);

    localparam int BEATS  = H_NUM * PIX_WIDTH / (8 * DQ_WIDTH);
    localparam int STRIDE = BEATS * 8;
    localparam int BW     = BUF_ADDR_WIDTH - 1;
    localparam int LAW    = LINE_ADDR_WIDTH;

    localparam logic [LAW-1:0]       STRIDE_L   = LAW'(STRIDE);
    // Bottom line base; deliberately truncated to the in-channel address width.
    localparam logic [LAW-1:0]       ROT_BASE   = LAW'((V_NUM - 1) * STRIDE);
    localparam logic [LAW-1:0]       BURST_STEP = LAW'(MAX_BURST * 8);
    localparam logic [LEN_WIDTH-1:0] BEATS_L    = LEN_WIDTH'(BEATS);
    localparam logic [LEN_WIDTH-1:0] MAXB_L     = LEN_WIDTH'(MAX_BURST);
    localparam logic [11:0]          V_NUM_L    = 12'(V_NUM);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    // Lowest enabled channel with index >= from; MSB flags that one was found.
    function automatic logic [CH_SEL_WIDTH:0] pick_ch(input logic [CH_NUM-1:0] mask,
                                                      input int from);
        logic [CH_SEL_WIDTH:0] res;
        res = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) begin
                res = {1'b1, CH_SEL_WIDTH'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [LEN_WIDTH-1:0] burst_len(input logic [LEN_WIDTH-1:0] remaining);
        if (remaining > MAXB_L) begin
            return MAXB_L;
        end else begin
            return remaining;
        end
    endfunction

    logic [2:0]                 state_q, state_d;
    logic                       rot_q, rot_d;
    logic [FRAME_IDX_WIDTH-1:0] fidx_q, fidx_d;
    logic [CH_NUM-1:0]          chen_q, chen_d;
    logic [11:0]                line_cnt_q, line_cnt_d;
    logic [1:0]                 pend_q, pend_d;
    logic [1:0]                 err_q, err_d;
    logic [LAW-1:0]             base_q, base_d;
    logic [LAW-1:0]             off_q, off_d;
    logic [CH_SEL_WIDTH-1:0]    ch_q, ch_d;
    logic [LEN_WIDTH-1:0]       issued_q, issued_d;   // beats requested so far for this channel
    logic [LEN_WIDTH-1:0]       len_q, len_d;
    logic [LEN_WIDTH-1:0]       bcnt_q, bcnt_d;       // beats received in the current burst
    logic [BW-1:0]              beat_q, beat_d;       // beat index within the channel's line
    logic                       rreq_q, rreq_d;
    logic [ADDR_WIDTH-1:0]      raddr_q, raddr_d;
    logic                       fdone_q, fdone_d;
    logic                       busy_q;

    logic                       line_done_s;
    logic                       start_line_s;
    logic                       pend_inc_s;
    logic                       pend_dec_s;
    logic [CH_SEL_WIDTH:0]      first_s;
    logic [CH_SEL_WIDTH:0]      next_s;
    logic [LEN_WIDTH-1:0]       cnt_now_s;
    logic [LEN_WIDTH-1:0]       nlen_s;
    logic [LAW-1:0]             line_addr_s;
    logic [BW-1:0]              ch_base_s;

    // Next-state logic for the scheduler FSM and all datapath registers.
    always_comb begin
        state_d      = state_q;
        rot_d        = rot_q;
        fidx_d       = fidx_q;
        chen_d       = chen_q;
        line_cnt_d   = line_cnt_q;
        pend_d       = pend_q;
        err_d        = err_q;
        base_d       = base_q;
        off_d        = off_q;
        ch_d         = ch_q;
        issued_d     = issued_q;
        len_d        = len_q;
        bcnt_d       = bcnt_q;
        beat_d       = beat_q;
        rreq_d       = rreq_q;
        fdone_d      = 1'b0;
        line_done_s  = 1'b0;
        start_line_s = 1'b0;
        pend_inc_s   = 1'b0;
        pend_dec_s   = 1'b0;
        nlen_s       = burst_len(BEATS_L - issued_q);
        first_s      = pick_ch(chen_q, 0);
        next_s       = pick_ch(chen_q, int'(ch_q) + 1);
        // rdone may coincide with the last beat, so include this cycle's beat.
        cnt_now_s    = bcnt_q + LEN_WIDTH'(ddr_rdata_en);

        case (state_q)
            S_IDLE: begin
                if ((line_req || pend_q != 2'd0) && line_cnt_q < V_NUM_L) begin
                    if (!line_req) begin
                        pend_dec_s = 1'b1;
                    end else begin
                        pend_dec_s = 1'b0;
                    end
                    if (chen_q == '0) begin
                        line_done_s = 1'b1;
                    end else begin
                        start_line_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (ddr_rrdy) begin
                    state_d = S_DATA;
                    rreq_d  = 1'b0;
                    bcnt_d  = '0;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_DATA: begin
                if (ddr_rdata_en) begin
                    beat_d = beat_q + BW'(1);
                    bcnt_d = bcnt_q + LEN_WIDTH'(1);
                end else begin
                    beat_d = beat_q;
                end
                if (ddr_rdone) begin
                    state_d = S_NEXT;
                    if (cnt_now_s != len_q) begin
                        err_d[1] = 1'b1;
                    end else begin
                        err_d[1] = err_q[1];
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_NEXT: begin
                if (issued_q < BEATS_L) begin
                    len_d    = nlen_s;
                    issued_d = issued_q + nlen_s;
                    off_d    = off_q + BURST_STEP;
                    state_d  = S_REQ;
                    rreq_d   = 1'b1;
                end else if (next_s[CH_SEL_WIDTH]) begin
                    ch_d     = next_s[CH_SEL_WIDTH-1:0];
                    off_d    = '0;
                    len_d    = burst_len(BEATS_L);
                    issued_d = burst_len(BEATS_L);
                    beat_d   = '0;
                    state_d  = S_REQ;
                    rreq_d   = 1'b1;
                end else begin
                    line_done_s = 1'b1;
                    if ((line_cnt_q + 12'd1) < V_NUM_L && pend_q != 2'd0) begin
                        pend_dec_s   = 1'b1;
                        start_line_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (ddr_rdone) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
                rreq_d  = 1'b0;
            end
        endcase

        if (line_done_s) begin
            line_cnt_d = line_cnt_q + 12'd1;
            base_d     = rot_q ? (base_q - STRIDE_L) : (base_q + STRIDE_L);
            beat_d     = '0;
            if ((line_cnt_q + 12'd1) == V_NUM_L) begin
                fdone_d = 1'b1;
                state_d = S_IDLE;
            end else begin
                fdone_d = 1'b0;
            end
        end else begin
            line_cnt_d = line_cnt_q;
        end

        if (start_line_s) begin
            ch_d     = first_s[CH_SEL_WIDTH-1:0];
            off_d    = '0;
            len_d    = burst_len(BEATS_L);
            issued_d = burst_len(BEATS_L);
            beat_d   = '0;
            bcnt_d   = '0;
            state_d  = S_REQ;
            rreq_d   = 1'b1;
        end else begin
            ch_d = ch_d;
        end

        // Requests arriving while a line is in flight are queued, up to three.
        if (state_q != S_IDLE && line_req && line_cnt_q < V_NUM_L) begin
            pend_inc_s = 1'b1;
        end else begin
            pend_inc_s = 1'b0;
        end
        if (pend_inc_s && !pend_dec_s) begin
            if (pend_q == 2'd3) begin
                err_d[0] = 1'b1;
            end else begin
                pend_d = pend_q + 2'd1;
            end
        end else if (!pend_inc_s && pend_dec_s) begin
            pend_d = pend_q - 2'd1;
        end else begin
            pend_d = pend_q;
        end

        // frame_start wins over everything else; a burst already accepted by
        // the controller must still be drained before going idle.
        if (frame_start) begin
            rot_d      = rotate_180;
            fidx_d     = frame_idx;
            chen_d     = ch_en;
            line_cnt_d = '0;
            err_d      = '0;
            fdone_d    = 1'b0;
            pend_d     = line_req ? 2'd1 : 2'd0;
            base_d     = rotate_180 ? ROT_BASE : '0;
            beat_d     = '0;
            rreq_d     = 1'b0;
            case (state_q)
                S_REQ:   state_d = ddr_rrdy ? S_DRAIN : S_IDLE;
                S_DATA:  state_d = ddr_rdone ? S_IDLE : S_DRAIN;
                S_DRAIN: state_d = ddr_rdone ? S_IDLE : S_DRAIN;
                default: state_d = S_IDLE;
            endcase
        end else begin
            rot_d = rot_d;
        end

        line_addr_s = base_d + off_d;
        raddr_d     = ADDR_WIDTH'({fidx_d, ch_d, line_addr_s}) + ADDR_OFFSET[ADDR_WIDTH-1:0];
    end

    // Line-buffer slot of the current channel within the line.
    always_comb begin
        ch_base_s = BW'(int'(ch_q) * BEATS);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state_q    <= S_IDLE;
            rot_q      <= 1'b0;
            fidx_q     <= '0;
            chen_q     <= '0;
            line_cnt_q <= '0;
            pend_q     <= 2'd0;
            err_q      <= 2'd0;
            base_q     <= '0;
            off_q      <= '0;
            ch_q       <= '0;
            issued_q   <= '0;
            len_q      <= '0;
            bcnt_q     <= '0;
            beat_q     <= '0;
            rreq_q     <= 1'b0;
            raddr_q    <= '0;
            fdone_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rot_q      <= rot_d;
            fidx_q     <= fidx_d;
            chen_q     <= chen_d;
            line_cnt_q <= line_cnt_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            base_q     <= base_d;
            off_q      <= off_d;
            ch_q       <= ch_d;
            issued_q   <= issued_d;
            len_q      <= len_d;
            bcnt_q     <= bcnt_d;
            beat_q     <= beat_d;
            rreq_q     <= rreq_d;
            raddr_q    <= raddr_d;
            fdone_q    <= fdone_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign ddr_rreq    = rreq_q;
    assign ddr_raddr   = raddr_q;
    assign ddr_rd_len  = len_q;
    assign ddr_part    = ch_q;
    // Beats are written in the cycle they arrive; drained beats are discarded.
    assign buf_wr_en   = ddr_rdata_en && (state_q == S_DATA);
    assign buf_wr_addr = {line_cnt_q[0], ch_base_s + beat_q};
    assign line_cnt    = line_cnt_q;
    assign busy        = busy_q;
    assign frame_done  = fdone_q;
    assign err_flags   = err_q;

endmodule

// File: tb/tb_rd_line_sched.sv
// Self-checking bench for rd_line_sched: expected requests and line-buffer
// writes are queued by the stimulus and popped by a monitor; a small DDR
// controller model answers requests.
module tb_rd_line_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs_main, fs_ctl, frame_start;
    logic        line_req, rotate_180;
    logic [0:0]  frame_idx;
    logic [3:0]  ch_en;
    logic        ddr_rreq, ddr_rrdy, ddr_rdata_en, ddr_rdone;
    logic [26:0] ddr_raddr;
    logic [15:0] ddr_rd_len;
    logic [1:0]  ddr_part;
    logic        buf_wr_en;
    logic [10:0] buf_wr_addr;
    logic [11:0] line_cnt;
    logic        busy, frame_done;
    logic [1:0]  err_flags;

    always #5 clk = ~clk;
    assign frame_start = fs_main | fs_ctl;

    rd_line_sched dut (
        .ddr_clk(clk), .ddr_rst(rst), .frame_start(frame_start), .line_req(line_req),
        .rotate_180(rotate_180), .frame_idx(frame_idx), .ch_en(ch_en),
        .ddr_rreq(ddr_rreq), .ddr_raddr(ddr_raddr), .ddr_rd_len(ddr_rd_len),
        .ddr_part(ddr_part), .ddr_rrdy(ddr_rrdy), .ddr_rdata_en(ddr_rdata_en),
        .ddr_rdone(ddr_rdone), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
        .line_cnt(line_cnt), .busy(busy), .frame_done(frame_done), .err_flags(err_flags)
    );

    typedef struct packed {
        logic [26:0] addr;
        logic [15:0] len;
        logic [1:0]  part;
    } req_t;

    req_t        exp_req_q[$];
    logic [10:0] exp_wr_q[$];
    int checks = 0;
    int passes = 0;
    int short_next = 0;   // beats withheld from the next burst
    int fs_at = -1;       // beat index at which the controller pulses frame_start
    int fd_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Expected traffic of one line: 64/64/52-beat bursts per enabled channel.
    task automatic push_line(input int fidx, input logic [3:0] mask, input int base,
                             input int par, input int nwr);
        req_t r;
        for (int ch = 0; ch < 4; ch++) begin
            if (mask[ch]) begin
                for (int b = 0; b < 180; b += 64) begin
                    r.addr = 27'((fidx << 21) | (ch << 19) | ((base + b * 8) % 524288));
                    r.len  = 16'(((180 - b) < 64) ? (180 - b) : 64);
                    r.part = 2'(ch);
                    exp_req_q.push_back(r);
                end
                for (int k = 0; k < nwr; k++) exp_wr_q.push_back(11'(par * 1024 + ch * 180 + k));
            end
        end
    endtask

    task automatic new_frame(input logic rot, input logic fidx, input logic [3:0] mask);
        @(posedge clk); #1;
        rotate_180 = rot; frame_idx = fidx; ch_en = mask; fs_main = 1'b1;
        @(posedge clk); #1;
        fs_main = 1'b0;
    endtask

    task automatic pulse_req();
        @(posedge clk); #1;
        line_req = 1'b1;
        @(posedge clk); #1;
        line_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic check_drained(input string name);
        check({name, "_req_q_empty"}, 32'(exp_req_q.size()), 32'd0);
        check({name, "_wr_q_empty"}, 32'(exp_wr_q.size()), 32'd0);
    endtask

    // DDR controller model: accept one cycle after seeing a request, then stream beats.
    initial begin
        int len, n, fa;
        ddr_rrdy = 1'b0; ddr_rdata_en = 1'b0; ddr_rdone = 1'b0; fs_ctl = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ddr_rreq && !rst) begin
                len = int'(ddr_rd_len);
                n   = len - short_next;
                fa  = fs_at;
                @(posedge clk); #1;
                ddr_rrdy = 1'b1;
                @(posedge clk); #1;
                ddr_rrdy = 1'b0;
                for (int i = 0; i < n; i++) begin
                    ddr_rdata_en = 1'b1;
                    fs_ctl = (i == fa);
                    @(posedge clk); #1;
                end
                ddr_rdata_en = 1'b0;
                fs_ctl = 1'b0;
                ddr_rdone = 1'b1;
                @(posedge clk); #1;
                ddr_rdone = 1'b0;
            end
        end
    end

    // Monitor: pops expected requests on accept and expected writes on buf_wr_en.
    initial begin
        req_t r;
        logic [10:0] w;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ddr_rreq && ddr_rrdy) begin
                    if (exp_req_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_req: got addr 0x%0h len %0d, expected no request",
                                 ddr_raddr, ddr_rd_len);
                    end else begin
                        r = exp_req_q.pop_front();
                        check("req_addr", 32'(ddr_raddr), 32'(r.addr));
                        check("req_len", 32'(ddr_rd_len), 32'(r.len));
                        check("req_part", 32'(ddr_part), 32'(r.part));
                    end
                end
                if (buf_wr_en) begin
                    if (exp_wr_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_wr: got addr 0x%0h, expected no write", buf_wr_addr);
                    end else begin
                        w = exp_wr_q.pop_front();
                        check("buf_wr_addr", 32'(buf_wr_addr), 32'(w));
                    end
                end
                if (frame_done) fd_pulses++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        rst = 1'b1; fs_main = 1'b0; line_req = 1'b0; rotate_180 = 1'b0;
        frame_idx = 1'b0; ch_en = 4'b0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rreq", 32'(ddr_rreq), 32'd0);
        check("rst_raddr", 32'(ddr_raddr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_line_cnt", 32'(line_cnt), 32'd0);
        check("rst_err", 32'(err_flags), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_buf_wr_en", 32'(buf_wr_en), 32'd0);

        // Single channel, frame 0: (0,64) (512,64) (1024,52), writes 0..179.
        new_frame(1'b0, 1'b0, 4'b0001);
        push_line(0, 4'b0001, 0, 0, 180);
        pulse_req();
        wait_idle(5000);
        check("t1_line_cnt", 32'(line_cnt), 32'd1);
        check("t1_err", 32'(err_flags), 32'd0);
        check_drained("t1");

        // Channels 1 and 3, frame 1: ch1 at 0x280000, ch3 at 0x380000; line 2 sets buffer MSB.
        new_frame(1'b0, 1'b1, 4'b1010);
        check("t2_line_cnt_cleared", 32'(line_cnt), 32'd0);
        push_line(1, 4'b1010, 0, 0, 180);
        pulse_req();
        wait_idle(5000);
        push_line(1, 4'b1010, 1440, 1, 180);
        pulse_req();
        wait_idle(5000);
        check("t2_line_cnt", 32'(line_cnt), 32'd2);
        check_drained("t2");

        // Bottom-up: 1079*1440 = 1553760, modulo 2^19 = 505184; next line 503744.
        new_frame(1'b1, 1'b0, 4'b0001);
        push_line(0, 4'b0001, 505184, 0, 180);
        pulse_req();
        wait_idle(5000);
        push_line(0, 4'b0001, 503744, 1, 180);
        pulse_req();
        wait_idle(5000);
        check("t3_line_cnt", 32'(line_cnt), 32'd2);
        check_drained("t3");

        // One request plus four more while busy: three queue, the fourth overruns.
        new_frame(1'b0, 1'b0, 4'b0001);
        push_line(0, 4'b0001, 0, 0, 180);
        push_line(0, 4'b0001, 1440, 1, 180);
        push_line(0, 4'b0001, 2880, 0, 180);
        push_line(0, 4'b0001, 4320, 1, 180);
        pulse_req();
        repeat (4) pulse_req();
        wait_idle(20000);
        check("t4_line_cnt", 32'(line_cnt), 32'd4);
        check("t4_err_overrun", 32'(err_flags), 32'd1);
        check_drained("t4");

        // First burst returns 63 of 64 beats: mismatch flagged, line still completes.
        new_frame(1'b0, 1'b0, 4'b0001);
        check("t5_err_cleared", 32'(err_flags), 32'd0);
        short_next = 1;
        push_line(0, 4'b0001, 0, 0, 179);
        pulse_req();
        repeat (3) @(posedge clk);
        short_next = 0;
        wait_idle(5000);
        check("t5_err_mismatch", 32'(err_flags), 32'd2);
        check("t5_line_cnt", 32'(line_cnt), 32'd1);
        check_drained("t5");

        // frame_start together with the 20th beat: remaining 44 beats are dropped.
        new_frame(1'b0, 1'b0, 4'b0001);
        frame_idx = 1'b1;
        fs_at = 19;
        exp_req_q.push_back('{addr: 27'd0, len: 16'd64, part: 2'd0});
        for (int k = 0; k < 20; k++) exp_wr_q.push_back(11'(k));
        pulse_req();
        repeat (3) @(posedge clk);
        fs_at = -1;
        wait_idle(5000);
        check("t6_line_cnt", 32'(line_cnt), 32'd0);
        check("t6_err", 32'(err_flags), 32'd0);
        check_drained("t6_drain");
        push_line(1, 4'b0001, 0, 0, 180);
        pulse_req();
        wait_idle(5000);
        check("t6_new_frame_line", 32'(line_cnt), 32'd1);
        check_drained("t6");

        // No channels enabled: each line_req completes at once; frame_done after 1080.
        new_frame(1'b0, 1'b0, 4'b0000);
        fd0 = fd_pulses;
        @(posedge clk); #1;
        line_req = 1'b1;
        repeat (1079) @(posedge clk);
        @(negedge clk);
        check("t7_line_cnt_1079", 32'(line_cnt), 32'd1079);
        check("t7_busy", 32'(busy), 32'd0);
        check("t7_no_done_yet", 32'(frame_done), 32'd0);
        @(posedge clk); #1;
        line_req = 1'b0;
        @(negedge clk);
        check("t7_line_cnt_1080", 32'(line_cnt), 32'd1080);
        check("t7_frame_done", 32'(frame_done), 32'd1);
        @(negedge clk);
        check("t7_frame_done_pulse", 32'(frame_done), 32'd0);
        pulse_req();
        @(negedge clk);
        check("t7_req_ignored", 32'(line_cnt), 32'd1080);
        check("t7_no_err", 32'(err_flags), 32'd0);
        check("t7_idle", 32'(busy), 32'd0);
        check("t7_done_count", 32'(fd_pulses - fd0), 32'd1);
        check_drained("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
